// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_COMMIT,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  // prot bit that marks a privileged access
  localparam int unsigned PROT_PRIV_BIT = 0;

  // Byte address to word index; low byte-lane bits are dropped so unaligned addresses alias.
  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                              input int unsigned data_width);
    if (data_width == 64) return addr >> 3;
    return addr >> 2;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Register array: one strobed write port, one combinational read port, flat view of all words.
module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_NUM_REGS   = 16,
  parameter int unsigned P_IDX_W      = 4,
  parameter logic [P_DATA_WIDTH-1:0] P_RESET_VAL = '0
) (
  input  logic                               clk,
  input  logic                               srst,
  input  logic                               we,
  input  logic [P_IDX_W-1:0]                 widx,
  input  logic [P_DATA_WIDTH-1:0]            wdata,
  input  logic [P_DATA_WIDTH/8-1:0]          wstrb,
  input  logic [P_IDX_W-1:0]                 ridx,
  output logic [P_DATA_WIDTH-1:0]            rdata_c,
  output logic [P_NUM_REGS*P_DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned STRB_W = P_DATA_WIDTH / 8;

  logic [P_DATA_WIDTH-1:0] wmask_c;
  logic [P_DATA_WIDTH-1:0] mem [P_NUM_REGS];

  for (genvar k = 0; k < STRB_W; k++) begin : g_mask
    assign wmask_c[k*8 +: 8] = {8{wstrb[k]}};
  end

  for (genvar g = 0; g < P_NUM_REGS; g++) begin : g_reg
    logic [P_DATA_WIDTH-1:0] q;

    // Word storage: reset to P_RESET_VAL, merge strobed bytes when this word is addressed.
    always_ff @(posedge clk) begin
      if (srst) begin
        q <= P_RESET_VAL;
      end else if (we && (widx == P_IDX_W'(g))) begin
        q <= (q & ~wmask_c) | (wdata & wmask_c);
      end
    end

    assign mem[g] = q;
    assign regs_o[g*P_DATA_WIDTH +: P_DATA_WIDTH] = q;
  end

  assign rdata_c = mem[ridx];

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave over a register file; AW/W accepted independently, byte strobes honoured.
// Optional privilege check: define AXI4L_SLV_PROT_CHECK_EN to reject unprivileged accesses.
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_ADDR_WIDTH = 32,
  parameter int unsigned P_NUM_REGS   = 16,
  parameter logic [P_DATA_WIDTH-1:0] P_RESET_VAL = '0
) (
  input  logic                               clk,
  input  logic                               srst,
  input  logic                               awvalid,
  output logic                               awready,
  input  logic [P_ADDR_WIDTH-1:0]            awaddr,
  input  logic [2:0]                         awprot,
  input  logic                               wvalid,
  output logic                               wready,
  input  logic [P_DATA_WIDTH-1:0]            wdata,
  input  logic [P_DATA_WIDTH/8-1:0]          wstrb,
  output logic                               bvalid,
  input  logic                               bready,
  output logic [1:0]                         bresp,
  input  logic                               arvalid,
  output logic                               arready,
  input  logic [P_ADDR_WIDTH-1:0]            araddr,
  input  logic [2:0]                         arprot,
  output logic                               rvalid,
  input  logic                               rready,
  output logic [P_DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                         rresp,
  output logic [P_NUM_REGS*P_DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned STRB_W = P_DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (P_NUM_REGS > 1) ? $clog2(P_NUM_REGS) : 1;

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  resp_t     bresp_q, bresp_d;
  resp_t     rresp_q, rresp_d;

  logic                    awready_d, wready_d, bvalid_d;
  logic                    arready_d, rvalid_d;
  logic [P_DATA_WIDTH-1:0] rdata_d;

  logic [P_ADDR_WIDTH-1:0] aw_addr_q;
  logic [2:0]              aw_prot_q;
  logic [P_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]       w_strb_q;

  logic aw_hs_c, w_hs_c, ar_hs_c;
  logic w_in_range_c, r_in_range_c, w_err_c, r_err_c, bank_we_c;
  logic [IDX_W-1:0]        w_idx_c, r_idx_c;
  logic [P_DATA_WIDTH-1:0] bank_rdata_c;

  assign aw_hs_c = awvalid && awready;
  assign w_hs_c  = wvalid && wready;
  assign ar_hs_c = arvalid && arready;

  assign w_in_range_c = addr_to_idx(64'(aw_addr_q), P_DATA_WIDTH) < 64'(P_NUM_REGS);
  assign r_in_range_c = addr_to_idx(64'(araddr), P_DATA_WIDTH) < 64'(P_NUM_REGS);
  assign w_idx_c      = IDX_W'(addr_to_idx(64'(aw_addr_q), P_DATA_WIDTH));
  assign r_idx_c      = IDX_W'(addr_to_idx(64'(araddr), P_DATA_WIDTH));

`ifdef AXI4L_SLV_PROT_CHECK_EN
  assign w_err_c = !w_in_range_c || !aw_prot_q[PROT_PRIV_BIT];
  assign r_err_c = !r_in_range_c || !arprot[PROT_PRIV_BIT];
`else
  logic unused_prot;
  assign unused_prot = ^{aw_prot_q, arprot};
  assign w_err_c     = !w_in_range_c;
  assign r_err_c     = !r_in_range_c;
`endif

  assign bank_we_c = (wr_state_q == W_COMMIT) && !w_err_c;
  assign bresp     = bresp_q;
  assign rresp     = rresp_q;

  axi4_lite_reg_bank #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_NUM_REGS   (P_NUM_REGS),
    .P_IDX_W      (IDX_W),
    .P_RESET_VAL  (P_RESET_VAL)
  ) u_bank (
    .clk     (clk),
    .srst    (srst),
    .we      (bank_we_c),
    .widx    (w_idx_c),
    .wdata   (w_data_q),
    .wstrb   (w_strb_q),
    .ridx    (r_idx_c),
    .rdata_c (bank_rdata_c),
    .regs_o  (regs_o)
  );

  // Capture write address and data on their own handshakes.
  always_ff @(posedge clk) begin
    if (aw_hs_c) begin
      aw_addr_q <= awaddr;
      aw_prot_q <= awprot;
    end
    if (w_hs_c) begin
      w_data_q <= wdata;
      w_strb_q <= wstrb;
    end
  end

  // Write channel next state; ready/valid derive from the state being entered.
  always_comb begin
    wr_state_d = wr_state_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) wr_state_d = W_COMMIT;
        else if (aw_hs_c)      wr_state_d = W_HAVE_ADDR;
        else if (w_hs_c)       wr_state_d = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_hs_c)  wr_state_d = W_COMMIT;
      W_HAVE_DATA: if (aw_hs_c) wr_state_d = W_COMMIT;
      W_COMMIT: begin
        wr_state_d = W_RESP;
        bresp_d    = w_err_c ? SLVERR : OKAY;
      end
      W_RESP:  if (bready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
    awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_DATA);
    wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_ADDR);
    bvalid_d  = (wr_state_d == W_RESP);
  end

  // Write channel state and registered outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_state_q <= W_IDLE;
      awready    <= 1'b1;
      wready     <= 1'b1;
      bvalid     <= 1'b0;
      bresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      awready    <= awready_d;
      wready     <= wready_d;
      bvalid     <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Read channel next state; data is captured from the bank at the AR handshake.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          rd_state_d = R_RESP;
          rdata_d    = r_err_c ? '0 : bank_rdata_c;
          rresp_d    = r_err_c ? SLVERR : OKAY;
        end
      end
      R_RESP:  if (rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
    rvalid_d  = (rd_state_d == R_RESP);
  end

  // Read channel state and registered outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_state_q <= R_IDLE;
      arready    <= 1'b1;
      rvalid     <= 1'b0;
      rdata      <= '0;
      rresp_q    <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready    <= arready_d;
      rvalid     <= rvalid_d;
      rdata      <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule
